// File: rtl/icache_direct_if.sv
// Fetch-side and memory-side handshake bundle for icache_direct.
// slave is the cache's view; master is the combined datapath/memory view.
interface icache_direct_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        flush;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport slave (
        input  imemREN, imemaddr, flush, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, flush, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache, single-word lines, register storage.
// Define ICACHE_STATS_EN to add hit_count/miss_count outputs.
module icache_direct #(
    parameter int unsigned SETS = 16
) (
    input logic            CLK,
    input logic            RST,
    icache_direct_if.slave bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]    hit_count,
    output logic [31:0]    miss_count
`endif
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE, FILL} state_t;

    state_t             state_q, state_d;
    logic [SETS-1:0]    valid_q;
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [31:0]        data_q [SETS];
    logic [31:0]        fill_addr_q;

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic [IDX_W-1:0]   fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic               hit;
    logic               start_fill;
    logic               install;
    logic               ihit;
    logic [31:0]        imemload;
    logic               iren;
    logic [31:0]        iaddr;
    logic               unused_addr_lsb;

    assign idx      = bus.imemaddr[IDX_W+1:2];
    assign tag      = bus.imemaddr[31:IDX_W+2];
    assign fill_idx = fill_addr_q[IDX_W+1:2];
    assign fill_tag = fill_addr_q[31:IDX_W+2];
    assign hit      = bus.imemREN & valid_q[idx] & (tag_q[idx] == tag);

    assign unused_addr_lsb = ^{bus.imemaddr[1:0], fill_addr_q[1:0]};

    always_comb begin
        state_d    = state_q;
        ihit       = 1'b0;
        imemload   = 32'h0;
        iren       = 1'b0;
        iaddr      = 32'h0;
        start_fill = 1'b0;
        install    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hit && !bus.flush) begin
                    ihit     = 1'b1;
                    imemload = data_q[idx];
                end
                if (bus.imemREN && !hit && !bus.flush) begin
                    start_fill = 1'b1;
                    state_d    = FILL;
                end
            end
            FILL: begin
                iren  = 1'b1;
                iaddr = fill_addr_q;
                // flush wins over a completing fill: nothing is installed
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (!bus.iwait) begin
                    install = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ihit     = ihit;
    assign bus.imemload = imemload;
    assign bus.iREN     = iren;
    assign bus.iaddr    = iaddr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            fill_addr_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (bus.flush) begin
                valid_q <= '0;
            end else if (install) begin
                valid_q[fill_idx] <= 1'b1;
            end
            if (start_fill) begin
                fill_addr_q <= {bus.imemaddr[31:2], 2'b00};
            end
        end
    end

    // Tag/data are left unreset; valid_q gates every use of them.
    always_ff @(posedge CLK) begin
        if (install) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= bus.iload;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_count  <= 32'h0;
            miss_count <= 32'h0;
        end else if (bus.flush) begin
            hit_count  <= 32'h0;
            miss_count <= 32'h0;
        end else begin
            if (ihit) begin
                hit_count <= hit_count + 32'd1;
            end
            if (start_fill) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Directed, table-driven bench for icache_direct; one row per clock cycle.
// Inputs are driven just after the rising edge, outputs sampled on the falling edge.
module tb_icache_direct;

    typedef struct {
        logic        ren;
        logic [31:0] addr;
        logic        flush;
        logic        iwait;
        logic [31:0] iload;
        logic        exp_ihit;
        logic [31:0] exp_load;
        logic        exp_iren;
        logic [31:0] exp_iaddr;
    } vec_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   tests = 0;
    int   failures = 0;

    icache_direct_if bus ();

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    icache_direct #(.SETS(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .bus        (bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    vec_t pre_q[$];
    vec_t post_q[$];

    function automatic vec_t mk(logic ren, logic [31:0] addr, logic fl, logic wt, logic [31:0] ld,
                                logic eh, logic [31:0] el, logic er, logic [31:0] ea);
        vec_t v;
        v.ren = ren; v.addr = addr; v.flush = fl; v.iwait = wt; v.iload = ld;
        v.exp_ihit = eh; v.exp_load = el; v.exp_iren = er; v.exp_iaddr = ea;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ren, input logic [31:0] addr, input logic fl,
                         input logic wt, input logic [31:0] ld);
        bus.imemREN  = ren;
        bus.imemaddr = addr;
        bus.flush    = fl;
        bus.iwait    = wt;
        bus.iload    = ld;
    endtask

    // Entered right at a rising edge; leaves at the next rising edge.
    task automatic apply(input vec_t v, input string name);
        #1 drive(v.ren, v.addr, v.flush, v.iwait, v.iload);
        @(negedge CLK);
        check({name, " ihit"},     {31'h0, bus.ihit}, {31'h0, v.exp_ihit});
        check({name, " imemload"}, bus.imemload,      v.exp_load);
        check({name, " iREN"},     {31'h0, bus.iREN}, {31'h0, v.exp_iren});
        check({name, " iaddr"},    bus.iaddr,         v.exp_iaddr);
        @(posedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // cold miss on 0x40 with 3 wait cycles
        pre_q.push_back(mk(1, 32'h40,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0));
        pre_q.push_back(mk(1, 32'h40,  0, 1, 32'h0,        0, 32'h0,        1, 32'h40));
        pre_q.push_back(mk(1, 32'h40,  0, 1, 32'h0,        0, 32'h0,        1, 32'h40));
        pre_q.push_back(mk(1, 32'h40,  0, 1, 32'h0,        0, 32'h0,        1, 32'h40));
        pre_q.push_back(mk(1, 32'h40,  0, 0, 32'h8C220004, 0, 32'h0,        1, 32'h40));
        pre_q.push_back(mk(1, 32'h40,  0, 1, 32'h0,        1, 32'h8C220004, 0, 32'h0));
        pre_q.push_back(mk(1, 32'h42,  0, 1, 32'h0,        1, 32'h8C220004, 0, 32'h0));
        // fill 0x04 with zero wait, then evict it with 0x44 (fill_addr latched, imemREN dropped)
        pre_q.push_back(mk(1, 32'h04,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0));
        pre_q.push_back(mk(1, 32'h04,  0, 0, 32'h11110004, 0, 32'h0,        1, 32'h04));
        pre_q.push_back(mk(1, 32'h04,  0, 1, 32'h0,        1, 32'h11110004, 0, 32'h0));
        pre_q.push_back(mk(1, 32'h44,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0));
        pre_q.push_back(mk(0, 32'h80,  0, 1, 32'h0,        0, 32'h0,        1, 32'h44));
        pre_q.push_back(mk(0, 32'h80,  0, 0, 32'h22220044, 0, 32'h0,        1, 32'h44));
        pre_q.push_back(mk(1, 32'h44,  0, 1, 32'h0,        1, 32'h22220044, 0, 32'h0));
        pre_q.push_back(mk(1, 32'h04,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0));
        pre_q.push_back(mk(1, 32'h04,  0, 0, 32'h11110004, 0, 32'h0,        1, 32'h04));
        pre_q.push_back(mk(1, 32'h04,  0, 1, 32'h0,        1, 32'h11110004, 0, 32'h0));
        pre_q.push_back(mk(1, 32'h40,  0, 1, 32'h0,        1, 32'h8C220004, 0, 32'h0));
        // flush lands on the same cycle iwait falls: fill aborted
        pre_q.push_back(mk(1, 32'h100, 0, 1, 32'h0,        0, 32'h0,        0, 32'h0));
        pre_q.push_back(mk(1, 32'h100, 0, 1, 32'h0,        0, 32'h0,        1, 32'h100));
        pre_q.push_back(mk(1, 32'h100, 1, 0, 32'h33330100, 0, 32'h0,        1, 32'h100));
        pre_q.push_back(mk(1, 32'h100, 0, 1, 32'h0,        0, 32'h0,        0, 32'h0));
        pre_q.push_back(mk(1, 32'h100, 0, 0, 32'h33330100, 0, 32'h0,        1, 32'h100));
        pre_q.push_back(mk(1, 32'h100, 0, 1, 32'h0,        1, 32'h33330100, 0, 32'h0));
        // flush held in IDLE masks a valid hit and starts no fill
        pre_q.push_back(mk(1, 32'h40,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0));
        pre_q.push_back(mk(1, 32'h40,  0, 0, 32'h99990040, 0, 32'h0,        1, 32'h40));
        pre_q.push_back(mk(1, 32'h40,  1, 1, 32'h0,        0, 32'h0,        0, 32'h0));
        pre_q.push_back(mk(1, 32'h40,  1, 1, 32'h0,        0, 32'h0,        0, 32'h0));
        pre_q.push_back(mk(1, 32'h40,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0));
        pre_q.push_back(mk(1, 32'h40,  0, 0, 32'h44440040, 0, 32'h0,        1, 32'h40));
        pre_q.push_back(mk(0, 32'h40,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0));
        pre_q.push_back(mk(1, 32'h40,  0, 1, 32'h0,        1, 32'h44440040, 0, 32'h0));

        // after mid-fill reset: everything misses; first row is the first cycle after release
        post_q.push_back(mk(1, 32'h40, 0, 1, 32'h0,        0, 32'h0,        0, 32'h0));
        post_q.push_back(mk(1, 32'h40, 0, 0, 32'h55550040, 0, 32'h0,        1, 32'h40));
        post_q.push_back(mk(1, 32'h44, 0, 1, 32'h0,        0, 32'h0,        0, 32'h0));
        post_q.push_back(mk(1, 32'h44, 0, 0, 32'h66660044, 0, 32'h0,        1, 32'h44));
        post_q.push_back(mk(1, 32'h04, 0, 1, 32'h0,        0, 32'h0,        0, 32'h0));
        post_q.push_back(mk(1, 32'h04, 1, 0, 32'h12345678, 0, 32'h0,        1, 32'h04));
        post_q.push_back(mk(1, 32'h04, 0, 1, 32'h0,        0, 32'h0,        0, 32'h0));
        post_q.push_back(mk(1, 32'h04, 0, 0, 32'h77770004, 0, 32'h0,        1, 32'h04));
        post_q.push_back(mk(1, 32'h04, 0, 1, 32'h0,        1, 32'h77770004, 0, 32'h0));
        post_q.push_back(mk(0, 32'h04, 0, 1, 32'h0,        0, 32'h0,        0, 32'h0));

        // reset state with a request already presented
        drive(1, 32'h40, 0, 1, 32'h0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset ihit",     {31'h0, bus.ihit}, 32'h0);
        check("reset imemload", bus.imemload,      32'h0);
        check("reset iREN",     {31'h0, bus.iREN}, 32'h0);
        check("reset iaddr",    bus.iaddr,         32'h0);
        @(posedge CLK);
        #1 RST = 1'b0;

        foreach (pre_q[i]) apply(pre_q[i], $sformatf("row%0d", i));

        // reset asserted between edges while in FILL
        #1 drive(1, 32'h200, 0, 1, 32'h0);
        @(negedge CLK);
        check("rstseq idle iREN", {31'h0, bus.iREN}, 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        check("rstseq fill iREN",  {31'h0, bus.iREN}, 32'h1);
        check("rstseq fill iaddr", bus.iaddr,         32'h200);
        #1 RST = 1'b1;
        #1;
        check("rstseq async iREN",  {31'h0, bus.iREN}, 32'h0);
        check("rstseq async iaddr", bus.iaddr,         32'h0);
        check("rstseq async ihit",  {31'h0, bus.ihit}, 32'h0);
        @(posedge CLK);
        @(posedge CLK);
        #1 RST = 1'b0;

        foreach (post_q[i]) apply(post_q[i], $sformatf("post%0d", i));

`ifdef ICACHE_STATS_EN
        #1 drive(0, 32'h0, 1, 1, 32'h0);
        @(posedge CLK);
        #1 drive(1, 32'h300, 0, 1, 32'h0);
        @(posedge CLK);
        #1 drive(1, 32'h300, 0, 0, 32'h88880300);
        @(posedge CLK);
        for (int k = 0; k < 5; k++) begin
            #1 drive(1, 32'h300, 0, 1, 32'h0);
            @(posedge CLK);
        end
        #1 drive(0, 32'h0, 0, 1, 32'h0);
        @(negedge CLK);
        check("stats hit_count",  hit_count,  32'd5);
        check("stats miss_count", miss_count, 32'd1);
        @(posedge CLK);
        #1 drive(0, 32'h0, 1, 1, 32'h0);
        @(posedge CLK);
        #1 drive(0, 32'h0, 0, 1, 32'h0);
        @(negedge CLK);
        check("stats flushed hit_count",  hit_count,  32'd0);
        check("stats flushed miss_count", miss_count, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
